// File: rtl/bit_scan_encoder_if.sv
// Handshake bundle for bit_scan_encoder: word input stream and per-bit index output stream.
// The optional out_count signal exists only when BIT_SCAN_POPCOUNT_EN is defined.
interface bit_scan_encoder_if #(
    parameter int WIDTH = 16
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_word;
    logic             in_msb_first;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic             out_empty;
`ifdef BIT_SCAN_POPCOUNT_EN
    logic [CNT_W-1:0] out_count;
`endif

    modport master (
        output in_valid, in_word, in_msb_first, out_ready,
`ifdef BIT_SCAN_POPCOUNT_EN
        input  out_count,
`endif
        input  in_ready, out_valid, out_index, out_last, out_empty
    );

    modport slave (
        input  in_valid, in_word, in_msb_first, out_ready,
`ifdef BIT_SCAN_POPCOUNT_EN
        output out_count,
`endif
        output in_ready, out_valid, out_index, out_last, out_empty
    );
endinterface

// File: rtl/bit_scan_encoder.sv
// Streaming bit-scan encoder: accepts a word, then emits one beat per set bit (LSB- or MSB-first).
// Optional popcount output enabled by defining BIT_SCAN_POPCOUNT_EN.
module bit_scan_encoder #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    bit_scan_encoder_if.slave   bus
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        EMPTY = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] residual, next_residual;
    logic             msb_first, next_msb_first;
    logic [IDX_W-1:0] scan_idx;
    logic             one_left;
    logic             in_fire, out_fire;

    // The last match in each loop wins, so the forward loop finds the highest bit.
    always_comb begin
        scan_idx = '0;
        if (msb_first) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (residual[i]) scan_idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (residual[i]) scan_idx = IDX_W'(i);
            end
        end
    end

    assign one_left = (residual != '0) && ((residual & (residual - WIDTH'(1))) == '0);

    assign bus.in_ready  = (state == IDLE) && clk_en;
    assign bus.out_valid = (state != IDLE) && clk_en;
    assign bus.out_index = (state == SCAN) ? scan_idx : '0;
    assign bus.out_last  = ((state == SCAN) && one_left) || (state == EMPTY);
    assign bus.out_empty = (state == EMPTY);

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_comb begin
        next_state     = state;
        next_residual  = residual;
        next_msb_first = msb_first;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    next_residual  = bus.in_word;
                    next_msb_first = bus.in_msb_first;
                    next_state     = (bus.in_word != '0) ? SCAN : EMPTY;
                end
            end
            SCAN: begin
                if (out_fire) begin
                    next_residual = residual & ~(WIDTH'(1) << scan_idx);
                    if (one_left) next_state = IDLE;
                end
            end
            EMPTY: begin
                if (out_fire) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            residual  <= '0;
            msb_first <= 1'b0;
        end else if (clk_en) begin
            state     <= next_state;
            residual  <= next_residual;
            msb_first <= next_msb_first;
        end
    end

`ifdef BIT_SCAN_POPCOUNT_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] count;

    // A zero word captures a count of 0, which is what EMPTY beats must report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clk_en && in_fire) begin
            count <= CNT_W'($countones(bus.in_word));
        end
    end

    assign bus.out_count = (state == SCAN) ? count : '0;
`endif
endmodule

// File: tb/tb_bit_scan_encoder.sv
// Self-checking bench for bit_scan_encoder: queue-based beat model plus directed and random words.
module tb_bit_scan_encoder;
    logic clk;
    logic rst;
    logic clk_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int idx;
        bit last;
        bit empty;
        int count;
    } beat_t;

    beat_t expQ[$];
    int    seen[$];
    int    seenLast[$];

    bit_scan_encoder_if #(.WIDTH(16)) bus ();

    bit_scan_encoder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .clk_en(clk_en),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats of one word, derived from its set bits.
    function automatic void pushBeats(input logic [15:0] w, input logic msb);
        int    idxs[$];
        int    n;
        beat_t b;
        for (int i = 0; i < 16; i++) if (w[i]) idxs.push_back(i);
        n = idxs.size();
        if (n == 0) begin
            b.idx = 0; b.last = 1'b1; b.empty = 1'b1; b.count = 0;
            expQ.push_back(b);
        end else begin
            for (int k = 0; k < n; k++) begin
                b.idx   = msb ? idxs[n-1-k] : idxs[k];
                b.last  = (k == n - 1);
                b.empty = 1'b0;
                b.count = n;
                expQ.push_back(b);
            end
        end
    endfunction

    // Compare process: outputs sampled on the falling edge, transfers predicted for the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            checkOutput("rst_in_ready", 32'(bus.in_ready), 32'(clk_en));
            checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
            checkOutput("in_ready", 32'(bus.in_ready), 32'(clk_en && expQ.size() == 0));
            checkOutput("out_valid", 32'(bus.out_valid), 32'(clk_en && expQ.size() != 0));
            if (bus.out_valid && expQ.size() != 0) begin
                checkOutput("out_index", 32'(bus.out_index), 32'(expQ[0].idx));
                checkOutput("out_last", 32'(bus.out_last), 32'(expQ[0].last));
                checkOutput("out_empty", 32'(bus.out_empty), 32'(expQ[0].empty));
`ifdef BIT_SCAN_POPCOUNT_EN
                checkOutput("out_count", 32'(bus.out_count), 32'(expQ[0].count));
`endif
                if (bus.out_ready) begin
                    seen.push_back(int'(bus.out_index));
                    seenLast.push_back(int'(bus.out_last));
                    void'(expQ.pop_front());
                end
            end
            if (clk_en && bus.in_valid && bus.in_ready) pushBeats(bus.in_word, bus.in_msb_first);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomizeCtl();
        clk_en        = ($urandom_range(0, 7) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Offers a word until it is accepted; returns one step after the accepting edge.
    task automatic applyStimulus(input logic [15:0] w, input logic msb, input bit rnd);
        bit accepted = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_word      = w;
        bus.in_msb_first = msb;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            accepted = bus.in_ready;
            tick();
            if (rnd) randomizeCtl();
            if (accepted) break;
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
        bus.in_valid     = 1'b0;
        bus.in_word      = 16'($urandom);
        bus.in_msb_first = 1'($urandom);
    endtask

    task automatic drainWord(input bit rnd);
        bit idle = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            idle = bus.in_ready;
            tick();
            if (idle) break;
            if (rnd) randomizeCtl();
        end
        if (!idle) checkOutput("drain_timeout", 32'd0, 32'd1);
        clk_en        = 1'b1;
        bus.out_ready = 1'b1;
    endtask

    task automatic checkSeen(input string name, input int exp[$]);
        checkOutput({name, "_beats"}, 32'(seen.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
            checkOutput({name, "_idx"}, 32'(seen[i]), 32'(exp[i]));
            checkOutput({name, "_last"}, 32'(seenLast[i]), 32'(i == exp.size() - 1));
        end
        seen.delete();
        seenLast.delete();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] w;
        int          sel;

        rst              = 1'b0;
        clk_en           = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_word      = '0;
        bus.in_msb_first = 1'b0;
        bus.out_ready    = 1'b1;

        #1 rst = 1'b1;
        #1;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_index", 32'(bus.out_index), 32'd0);
        checkOutput("reset_out_last", 32'(bus.out_last), 32'd0);
        checkOutput("reset_out_empty", 32'(bus.out_empty), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] LSB-first and MSB-first scans of 8421");
        applyStimulus(16'h8421, 1'b0, 1'b0);
        drainWord(1'b0);
        checkSeen("lsb_8421", '{0, 5, 10, 15});
        applyStimulus(16'h8421, 1'b1, 1'b0);
        drainWord(1'b0);
        checkSeen("msb_8421", '{15, 10, 5, 0});

        $display("[TB] zero word");
        applyStimulus(16'h0000, 1'b0, 1'b0);
        drainWord(1'b0);
        checkSeen("zero", '{0});

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(16'h0003, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_index", 32'(bus.out_index), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        drainWord(1'b0);
        checkSeen("bp", '{0, 1});

        $display("[TB] freeze and reset mid-scan");
        applyStimulus(16'hFFFF, 1'b0, 1'b0);
        tick();
        clk_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("freeze_valid", 32'(bus.out_valid), 32'd0);
            checkOutput("freeze_index", 32'(bus.out_index), 32'd1);
            tick();
        end
        clk_en = 1'b1;
        for (int n = 0; n < 20 && seen.size() < 3; n++) tick();
        checkOutput("pre_reset_beats", 32'(seen.size()), 32'd3);
        #1 rst = 1'b1;
        #1;
        checkOutput("midscan_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midscan_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midscan_out_index", 32'(bus.out_index), 32'd0);
        checkOutput("midscan_out_last", 32'(bus.out_last), 32'd0);
        tick();
        rst = 1'b0;
        seen.delete();
        seenLast.delete();
        applyStimulus(16'h0010, 1'b0, 1'b0);
        drainWord(1'b0);
        checkSeen("after_reset", '{4});

        $display("[TB] randomized words");
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            w   = 16'($urandom);
            if (sel == 0)      w = 16'h0000;
            else if (sel == 1) w = 16'hFFFF;
            else if (sel == 2) w = 16'(1) << $urandom_range(0, 15);
            else if (sel == 3) w = w & 16'($urandom);
            applyStimulus(w, 1'($urandom_range(0, 1)), 1'b1);
            drainWord(1'b1);
        end
        tick();
        tick();
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bit_scan_encoder.md
Name: bit_scan_encoder

Overview:
- Streaming, parametrised successor to the single-cycle priority encoder.
- Accepts one WIDTH-bit word per handshake.
- Emits the index of every set bit, one index per output beat, in LSB-first or MSB-first order, with a last flag.
- Used by control logic to walk active-lane masks, e.g. which heads or channels need servicing.

Parameters:
- WIDTH, 16, input word width; legal range ≥ 2.
- IDX_W, $clog2(WIDTH), width of the index output; derived, not to be overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- clk_en  in  1  clock enable; when 0 all state is frozen.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_word  in  WIDTH  word to scan.
- in_msb_first  in  1  scan order for this word: 0 = LSB-first, 1 = MSB-first. Captured with the word.
- out_valid  out  1  out_index is valid.
- out_ready  in  1  downstream accepts the beat.
- out_index  out  IDX_W  index of the current set bit.
- out_last  out  1  current beat is the final beat for this word.
- out_empty  out  1  accepted word was all-zero; this beat carries no index.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE, residual register = 0, order flag = 0.
  - in_ready=1, out_valid=0, out_index=0, out_last=0, out_empty=0.
  - All values hold until rst is released.
- States: IDLE, SCAN, EMPTY.
- Handshakes:
  - Both are valid/ready; a transfer occurs only on a rising edge with clk_en=1 and valid&ready=1.
  - in_ready = (state==IDLE) & clk_en.
  - out_valid = (state!=IDLE) & clk_en.
- IDLE:
  - On input transfer, capture in_word into the residual register and in_msb_first into the order flag.
  - Next state is SCAN if in_word != 0, otherwise EMPTY.
  - First output beat is valid the cycle after acceptance (latency 1).
- SCAN:
  - out_index = lowest set bit of residual (LSB-first) or highest set bit (MSB-first).
  - Computed combinationally from registered state; stable while out_valid=1 and out_ready=0.
  - out_last = 1 when exactly one bit remains in residual.
  - On output transfer: clear the emitted bit in residual. If out_last was 1, go to IDLE; else stay in SCAN.
- EMPTY:
  - Single beat with out_index=0, out_empty=1, out_last=1.
  - On output transfer, go to IDLE.
- Throughput: N set bits produce N beats. One idle cycle separates words, since in_ready is only high in IDLE.
- Backpressure: out_ready=0 holds state, residual and all outputs unchanged. out_valid stays asserted while clk_en=1 and must not drop.
- clk_en=0:
  - No register changes.
  - in_ready and out_valid are forced 0, so no transfer can occur.
  - Resumes exactly where it stopped.
- Boundary cases:
  - All-ones word: WIDTH beats; indices 0..WIDTH-1 for LSB-first, reverse for MSB-first.
  - in_word changes while in_ready=0: ignored.
  - rst asserted mid-scan: residual discarded immediately; no partial completion.
  - in_msb_first sampled only at acceptance.
- Arithmetic: IDX_W = $clog2(WIDTH). Indices are unsigned in the range 0..WIDTH-1.

Optional Feature:
- Macro: BIT_SCAN_POPCOUNT_EN.
- Defined:
  - Adds output port out_count, width $clog2(WIDTH+1).
  - Holds the popcount of the accepted word, registered at acceptance.
  - Held constant on every beat of that word; 0 on EMPTY beats; reset value 0.
- Not defined: port and counting logic absent; all other behaviour identical.

Test Plan:
- Reset state: assert rst mid-cycle (async) -> immediately in_ready=1, out_valid=0, out_index=0, out_last=0, out_empty=0.
- LSB-first word: in_word=16'h8421, in_msb_first=0, out_ready=1 -> beats at accept+1..+4 with indices 0, 5, 10, 15; out_last=1 only on 15; in_ready returns 1 the next cycle.
- MSB-first word: same word with in_msb_first=1 -> indices 15, 10, 5, 0, last on 0. With BIT_SCAN_POPCOUNT_EN defined, out_count=4 on all beats.
- Zero word: in_word=0 -> exactly one beat with out_empty=1, out_last=1, out_index=0; then IDLE.
- Backpressure: word 16'h0003, out_ready low for 3 cycles -> out_index=0 held with out_valid=1; after release, beats 0 then 1 (last).
- Freeze and reset mid-scan: clk_en=0 for 2 cycles during scan of 16'hFFFF -> no index advance, out_valid=0. Then rst after the 3rd beat -> IDLE; the next word 16'h0010 yields the single beat 4 (last).
